sram_ctrl_param: RTL and testbench

Parametrised asynchronous-SRAM controller: the next-generation memory port between on-chip request logic and an external async SRAM. It adds generic address and data widths, programmable read and write wait states, byte-lane write enables, a read-to-write bus turnaround, and a valid/ready request channel with a one-cycle response strobe. The controller drives the bidirectional SRAM data bus only during write phases.

---
 rtl/sram_ctrl_param.sv | 163 ++++++++++++++++
 tb/tb_sram_ctrl_param.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_ctrl_param.sv
// sram_ctrl_param: valid/ready front end for an external asynchronous SRAM.
// Programmable read/write wait states, byte-lane write enables and an idle
// turnaround after reads. The data bus is driven only across write phases.

// One byte lane: holds the lane's write byte and its active-low lane enable.
module sram_ctrl_lane (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] byte_in,
  input  logic       be_in,
  input  logic       nxt_wr,
  input  logic       nxt_rd,
  output logic [7:0] byte_q,
  output logic       be_n
);
  logic be_q;
  logic be_cur;

  // The enable of a request being accepted must already apply on that edge.
  assign be_cur = load ? be_in : be_q;

  // Latch lane data at write accept; be_n follows the phase being entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_q <= '0;
      be_q   <= 1'b0;
      be_n   <= 1'b1;
    end else begin
      if (load) begin
        byte_q <= byte_in;
        be_q   <= be_in;
      end
      be_n <= nxt_wr ? ~be_cur : (nxt_rd ? 1'b0 : 1'b1);
    end
  end
endmodule

module sram_ctrl_param #(
  parameter  int ADDR_W     = 15,
  parameter  int DATA_W     = 16,
  parameter  int READ_WAIT  = 2,
  parameter  int WRITE_WAIT = 2,
  parameter  int TURNAROUND = 1,
  localparam int BE_W       = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [BE_W-1:0]   req_be,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] sram_addr,
  inout  wire  [DATA_W-1:0] sram_data,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic [BE_W-1:0]   sram_be_n
);
  localparam int MAX_RW   = (READ_WAIT > WRITE_WAIT) ? READ_WAIT : WRITE_WAIT;
  localparam int MAX_WAIT = (MAX_RW > TURNAROUND) ? MAX_RW : TURNAROUND;
  localparam int CNT_W    = $clog2(MAX_WAIT + 1);

  // Counter reload values: a phase of N cycles counts N-1 down to 0.
  localparam logic [CNT_W-1:0] RD_LOAD   = CNT_W'(READ_WAIT - 1);
  localparam logic [CNT_W-1:0] WR_LOAD   = CNT_W'(WRITE_WAIT - 1);
  localparam logic [CNT_W-1:0] TURN_LOAD = CNT_W'((TURNAROUND > 0) ? TURNAROUND - 1 : 0);

  typedef enum logic [2:0] {IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, TURN} state_t;

  state_t                 state, nxt;
  logic [CNT_W-1:0]       cnt, nxt_cnt;
  logic                   accept;
  logic                   nxt_wr, nxt_rd;
  logic                   rd_done;
  logic                   drive;
  logic [BE_W-1:0][7:0]   wbyte;

  assign req_ready = (state == IDLE) && !rst;
  assign accept    = req_valid && req_ready;
  assign rd_done   = (state == RD) && (cnt == '0);

  // Next state and shared wait counter.
  always_comb begin
    nxt     = state;
    nxt_cnt = cnt;
    case (state)
      IDLE: if (accept) begin
        nxt     = req_write ? WR_SETUP : RD;
        nxt_cnt = req_write ? '0 : RD_LOAD;
      end
      RD: if (cnt == '0) begin
        if (TURNAROUND > 0) begin
          nxt     = TURN;
          nxt_cnt = TURN_LOAD;
        end else begin
          nxt = IDLE;
        end
      end else begin
        nxt_cnt = cnt - 1'b1;
      end
      WR_SETUP: begin
        nxt     = WR_PULSE;
        nxt_cnt = WR_LOAD;
      end
      WR_PULSE: if (cnt == '0) nxt = WR_HOLD;
                else           nxt_cnt = cnt - 1'b1;
      WR_HOLD:  nxt = IDLE;
      TURN:     if (cnt == '0) nxt = IDLE;
                else           nxt_cnt = cnt - 1'b1;
      default:  nxt = IDLE;
    endcase
    nxt_wr = (nxt == WR_SETUP) || (nxt == WR_PULSE) || (nxt == WR_HOLD);
    nxt_rd = (nxt == RD);
  end

  // State, strobes and response; strobes are decoded from the state being
  // entered so every SRAM-facing pin comes straight from a flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      sram_ce_n <= 1'b1;
      sram_oe_n <= 1'b1;
      sram_we_n <= 1'b1;
      drive     <= 1'b0;
      sram_addr <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state     <= nxt;
      cnt       <= nxt_cnt;
      sram_ce_n <= !(nxt_wr || nxt_rd);
      sram_oe_n <= !nxt_rd;
      sram_we_n <= (nxt != WR_PULSE);
      drive     <= nxt_wr;
      if (accept) sram_addr <= req_addr;
      rsp_valid <= rd_done || (state == WR_HOLD);
      if (rd_done) rsp_rdata <= sram_data;
    end
  end

  for (genvar i = 0; i < BE_W; i++) begin : g_lane
    sram_ctrl_lane u_lane (
      .clk     (clk),
      .rst     (rst),
      .load    (accept && req_write),
      .byte_in (req_wdata[i*8 +: 8]),
      .be_in   (req_be[i]),
      .nxt_wr  (nxt_wr),
      .nxt_rd  (nxt_rd),
      .byte_q  (wbyte[i]),
      .be_n    (sram_be_n[i])
    );
  end

  // Bus is released whenever no write phase is active, including in reset.
  assign sram_data = drive ? wbyte : 'z;
endmodule

// File: tb/tb_sram_ctrl_param.sv
`timescale 1ns/1ps
module tb_sram_ctrl_param;
  localparam int AW = 15, DW = 16, BW = 2, RW = 2, WW = 2, TA = 1;
  localparam int AW2 = 10, DW2 = 32, BW2 = 4, RW2 = 1, WW2 = 4, TA2 = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // ---------------- DUT 1: default parameters ----------------
  logic          req_valid = 0, req_write = 0;
  logic          req_ready, rsp_valid;
  logic [AW-1:0] req_addr = '0, sram_addr;
  logic [DW-1:0] req_wdata = '0, rsp_rdata;
  logic [BW-1:0] req_be = '0, be_n;
  logic          ce_n, oe_n, we_n;
  wire  [DW-1:0] sram_data;

  sram_ctrl_param u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_be(req_be), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .sram_addr(sram_addr), .sram_data(sram_data), .sram_ce_n(ce_n),
    .sram_oe_n(oe_n), .sram_we_n(we_n), .sram_be_n(be_n)
  );

  // ---------------- DUT 2: parameter sweep ----------------
  logic           req_valid2 = 0, req_write2 = 0;
  logic           req_ready2, rsp_valid2;
  logic [AW2-1:0] req_addr2 = '0, sram_addr2;
  logic [DW2-1:0] req_wdata2 = '0, rsp_rdata2;
  logic [BW2-1:0] req_be2 = '0, be_n2;
  logic           ce_n2, oe_n2, we_n2;
  wire  [DW2-1:0] sram_data2;

  sram_ctrl_param #(.ADDR_W(AW2), .DATA_W(DW2), .READ_WAIT(RW2),
                    .WRITE_WAIT(WW2), .TURNAROUND(TA2)) u_dut2 (
    .clk(clk), .rst(rst), .req_valid(req_valid2), .req_ready(req_ready2),
    .req_write(req_write2), .req_addr(req_addr2), .req_wdata(req_wdata2),
    .req_be(req_be2), .rsp_valid(rsp_valid2), .rsp_rdata(rsp_rdata2),
    .sram_addr(sram_addr2), .sram_data(sram_data2), .sram_ce_n(ce_n2),
    .sram_oe_n(oe_n2), .sram_we_n(we_n2), .sram_be_n(be_n2)
  );

  // ---------------- async SRAM models ----------------
  logic [DW-1:0]  mem1 [0:(1<<AW)-1];
  logic [DW2-1:0] mem2 [0:(1<<AW2)-1];
  logic           probe_en = 0;
  logic [DW-1:0]  probe_val = '0;

  initial begin
    for (int i = 0; i < (1<<AW); i++) mem1[i] = '0;
    for (int i = 0; i < (1<<AW2); i++) mem2[i] = '0;
  end

  assign sram_data  = (!ce_n && !oe_n && we_n) ? mem1[sram_addr] : (probe_en ? probe_val : 'z);
  assign sram_data2 = (!ce_n2 && !oe_n2 && we_n2) ? mem2[sram_addr2] : 'z;

  always @(posedge clk) begin
    logic [DW-1:0]  w1;
    logic [DW2-1:0] w2;
    if (!ce_n && !we_n) begin
      w1 = mem1[sram_addr];
      for (int i = 0; i < BW; i++) if (!be_n[i]) w1[i*8 +: 8] = sram_data[i*8 +: 8];
      mem1[sram_addr] <= w1;
    end
    if (!ce_n2 && !we_n2) begin
      w2 = mem2[sram_addr2];
      for (int i = 0; i < BW2; i++) if (!be_n2[i]) w2[i*8 +: 8] = sram_data2[i*8 +: 8];
      mem2[sram_addr2] <= w2;
    end
  end

  // ---------------- bus monitors (sampled on the falling edge) ----------------
  int viol1 = 0, viol2 = 0;
  int plen1 = 0, last_len1 = 0, plen2 = 0, last_len2 = 0;
  logic [BW-1:0] pulse_be1 = '1;
  logic          pwe1 = 1;
  logic [AW-1:0] paddr1 = '0;
  logic [BW-1:0] pbe1 = '1;
  logic [DW-1:0] pdat1 = '0;

  always @(negedge clk) begin
    if (rst) begin
      plen1 = 0;
      plen2 = 0;
    end else begin
      if (!oe_n && !we_n) viol1++;
      if (!ce_n && !oe_n && sram_data !== mem1[sram_addr]) viol1++;
      if (we_n != pwe1 && (sram_addr !== paddr1 || be_n !== pbe1 || sram_data !== pdat1)) viol1++;
      if (!we_n) begin plen1++; pulse_be1 = be_n; end
      else if (plen1 > 0) begin last_len1 = plen1; plen1 = 0; end
      if (!oe_n2 && !we_n2) viol2++;
      if (!ce_n2 && !oe_n2 && sram_data2 !== mem2[sram_addr2]) viol2++;
      if (!we_n2) plen2++;
      else if (plen2 > 0) begin last_len2 = plen2; plen2 = 0; end
    end
    pwe1 = we_n; paddr1 = sram_addr; pbe1 = be_n; pdat1 = sram_data;
  end

  // ---------------- reference model ----------------
  logic [DW-1:0]  ref1 [int];
  logic [DW2-1:0] ref2 [int];

  function automatic logic [DW-1:0] rget1(input int a);
    return ref1.exists(a) ? ref1[a] : '0;
  endfunction

  function automatic logic [DW-1:0] lmask1(input logic [BW-1:0] be);
    logic [DW-1:0] m;
    for (int i = 0; i < BW; i++) m[i*8 +: 8] = be[i] ? 8'hFF : 8'h00;
    return m;
  endfunction

  function automatic void rwrite1(input int a, input logic [DW-1:0] d, input logic [BW-1:0] be);
    ref1[a] = (rget1(a) & ~lmask1(be)) | (d & lmask1(be));
  endfunction

  // ---------------- drivers (all activity at posedge+1) ----------------
  task automatic do1(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                     input logic [BW-1:0] be, output logic [DW-1:0] rd, output int lat);
    int n;
    lat = -1;
    rd  = '0;
    req_valid = 1; req_write = wr; req_addr = a; req_wdata = d; req_be = be;
    n = 0;
    while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (!req_ready) begin req_valid = 0; return; end
    @(posedge clk); #1;
    // Scramble inputs after accept: the request must already be latched.
    req_valid = 0; req_write = 1'($urandom); req_addr = AW'($urandom);
    req_wdata = DW'($urandom); req_be = BW'($urandom);
    n = 0;
    while (!rsp_valid && n < 50) begin @(posedge clk); #1; n++; end
    if (rsp_valid) lat = n;
    rd = rsp_rdata;
  endtask

  task automatic do2(input logic wr, input logic [AW2-1:0] a, input logic [DW2-1:0] d,
                     input logic [BW2-1:0] be, output logic [DW2-1:0] rd, output int lat);
    int n;
    lat = -1;
    rd  = '0;
    req_valid2 = 1; req_write2 = wr; req_addr2 = a; req_wdata2 = d; req_be2 = be;
    n = 0;
    while (!req_ready2 && n < 50) begin @(posedge clk); #1; n++; end
    if (!req_ready2) begin req_valid2 = 0; return; end
    @(posedge clk); #1;
    req_valid2 = 0; req_addr2 = AW2'($urandom); req_wdata2 = $urandom;
    n = 0;
    while (!rsp_valid2 && n < 50) begin @(posedge clk); #1; n++; end
    if (rsp_valid2) lat = n;
    rd = rsp_rdata2;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    checks++; if (rsp_rdata !== '0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", rsp_rdata); end
    checks++; if ({ce_n, oe_n, we_n} !== 3'b111) begin failures++; $display("FAIL reset_strobes got=%b exp=111", {ce_n, oe_n, we_n}); end
    checks++; if (be_n !== 2'b11) begin failures++; $display("FAIL reset_be_n got=%b exp=11", be_n); end
    checks++; if (sram_addr !== '0) begin failures++; $display("FAIL reset_addr got=%h exp=0", sram_addr); end
    checks++; if ({ce_n2, oe_n2, we_n2, be_n2} !== 7'h7F) begin failures++; $display("FAIL reset_dut2_strobes got=%b exp=1111111", {ce_n2, oe_n2, we_n2, be_n2}); end
    probe_en = 1; probe_val = 16'hA55A; #1;
    checks++; if (sram_data !== 16'hA55A) begin failures++; $display("FAIL reset_bus_released got=%h exp=a55a", sram_data); end
    probe_en = 0;
    @(posedge clk); #1;
    rst = 0; #1;
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_release_ready got=%b exp=1", req_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_write_read();
    logic [DW-1:0] rd; int lat;
    do1(1, 15'h1234, 16'hABCD, 2'b11, rd, lat); rwrite1('h1234, 16'hABCD, 2'b11);
    checks++; if (lat != WW + 2) begin failures++; $display("FAIL wr_latency got=%0d exp=%0d", lat, WW + 2); end
    checks++; if (last_len1 != WW) begin failures++; $display("FAIL wr_pulse_len got=%0d exp=%0d", last_len1, WW); end
    do1(0, 15'h1234, 16'h0, 2'b00, rd, lat);
    checks++; if (lat != RW) begin failures++; $display("FAIL rd_latency got=%0d exp=%0d", lat, RW); end
    checks++; if (rd !== 16'hABCD) begin failures++; $display("FAIL rd_data got=%h exp=abcd", rd); end
    @(posedge clk); #1;
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rsp_single_pulse got=%b exp=0", rsp_valid); end
  endtask

  task automatic test_byte_lanes();
    logic [DW-1:0] rd; int lat;
    do1(1, 15'h0010, 16'h5A5A, 2'b11, rd, lat); rwrite1('h10, 16'h5A5A, 2'b11);
    do1(1, 15'h0010, 16'h1234, 2'b01, rd, lat); rwrite1('h10, 16'h1234, 2'b01);
    checks++; if (pulse_be1 !== 2'b10) begin failures++; $display("FAIL lane_be_n got=%b exp=10", pulse_be1); end
    do1(0, 15'h0010, 16'h0, 2'b00, rd, lat);
    checks++; if (rd !== 16'h5A34) begin failures++; $display("FAIL lane_merge got=%h exp=5a34", rd); end
    do1(1, 15'h0010, 16'hFFFF, 2'b00, rd, lat); rwrite1('h10, 16'hFFFF, 2'b00);
    checks++; if (lat != WW + 2) begin failures++; $display("FAIL lane_zero_be_latency got=%0d exp=%0d", lat, WW + 2); end
    do1(0, 15'h0010, 16'h0, 2'b00, rd, lat);
    checks++; if (rd !== rget1('h10)) begin failures++; $display("FAIL lane_zero_be_data got=%h exp=%h", rd, rget1('h10)); end
  endtask

  task automatic test_turnaround();
    logic [DW-1:0] rd; int lat, n, v0;
    do1(1, 15'h0001, 16'h3C3C, 2'b11, rd, lat); rwrite1(1, 16'h3C3C, 2'b11);
    v0 = viol1;
    req_valid = 1; req_write = 0; req_addr = 15'h0001;
    n = 0;
    while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    req_write = 1; req_addr = 15'h0002; req_wdata = 16'hC3C3; req_be = 2'b11;
    n = 0;
    while (!rsp_valid && n < 50) begin @(posedge clk); #1; n++; end
    checks++; if (n != RW || rsp_rdata !== 16'h3C3C) begin failures++; $display("FAIL turn_read got=%0d/%h exp=%0d/3c3c", n, rsp_rdata, RW); end
    n = 0;
    while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
    checks++; if (n != TA) begin failures++; $display("FAIL turn_ready_gap got=%0d exp=%0d", n, TA); end
    @(posedge clk); #1;
    req_valid = 0; rwrite1(2, 16'hC3C3, 2'b11);
    n = 0;
    while (!rsp_valid && n < 50) begin @(posedge clk); #1; n++; end
    checks++; if (n != WW + 2) begin failures++; $display("FAIL turn_write_latency got=%0d exp=%0d", n, WW + 2); end
    checks++; if (viol1 != v0) begin failures++; $display("FAIL turn_bus_conflict got=%0d exp=%0d", viol1, v0); end
    do1(0, 15'h0002, 16'h0, 2'b00, rd, lat);
    checks++; if (rd !== 16'hC3C3) begin failures++; $display("FAIL turn_write_data got=%h exp=c3c3", rd); end
  endtask

  task automatic test_streaming();
    logic [AW-1:0] addrs [8];
    logic [DW-1:0] got [8];
    int acc_c [8];
    logic [DW-1:0] rd; int lat, na, nr;
    bit acc;
    for (int k = 0; k < 8; k++) begin
      addrs[k] = AW'(16'h0100 + k * 16 + $urandom_range(0, 15));
      rd = DW'($urandom);
      do1(1, addrs[k], rd, 2'b11, rd, lat);
      rwrite1(int'(addrs[k]), mem1[addrs[k]], 2'b11);
    end
    na = 0; nr = 0;
    req_valid = 1; req_write = 0; req_addr = addrs[0];
    for (int c = 0; c < 300 && nr < 8; c++) begin
      acc = req_ready && req_valid;
      @(posedge clk); #1;
      if (acc) begin
        acc_c[na] = c; na++;
        if (na < 8) req_addr = addrs[na]; else req_valid = 0;
      end
      if (rsp_valid && nr < 8) begin got[nr] = rsp_rdata; nr++; end
    end
    req_valid = 0;
    checks++; if (nr != 8) begin failures++; $display("FAIL stream_count got=%0d exp=8", nr); end
    for (int k = 0; k < nr; k++) begin
      checks++; if (got[k] !== rget1(int'(addrs[k]))) begin failures++; $display("FAIL stream_data[%0d] got=%h exp=%h", k, got[k], rget1(int'(addrs[k]))); end
      if (k > 0) begin
        checks++; if (acc_c[k] - acc_c[k-1] != RW + TA + 1) begin failures++; $display("FAIL stream_period[%0d] got=%0d exp=%0d", k, acc_c[k] - acc_c[k-1], RW + TA + 1); end
      end
    end
  endtask

  task automatic test_random();
    logic [DW-1:0] rd, d, last, exp; logic [AW-1:0] a; logic [BW-1:0] be; logic wr; int lat;
    last = '0;
    for (int k = 0; k < 40; k++) begin
      wr = (k == 0) ? 1'b0 : 1'($urandom);
      a  = AW'(16'h0200 + $urandom_range(0, 15));
      d  = DW'($urandom); be = BW'($urandom);
      do1(wr, a, d, be, rd, lat);
      checks++; if (lat != (wr ? WW + 2 : RW)) begin failures++; $display("FAIL rand_latency[%0d] got=%0d exp=%0d", k, lat, wr ? WW + 2 : RW); end
      if (wr) begin
        rwrite1(int'(a), d, be);
        checks++; if (rd !== last) begin failures++; $display("FAIL rand_rdata_hold[%0d] got=%h exp=%h", k, rd, last); end
      end else begin
        exp = rget1(int'(a));
        checks++; if (rd !== exp) begin failures++; $display("FAIL rand_read[%0d] got=%h exp=%h", k, rd, exp); end
        last = exp;
      end
    end
  endtask

  task automatic test_reset_mid_write();
    int n, seen;
    req_valid = 1; req_write = 1; req_addr = 15'h0020; req_wdata = 16'h1234; req_be = 2'b11;
    n = 0;
    while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    req_valid = 0;
    n = 0;
    while (we_n && n < 20) begin @(posedge clk); #1; n++; end
    checks++; if (we_n !== 1'b0) begin failures++; $display("FAIL abort_reach_pulse got=%b exp=0", we_n); end
    #2 rst = 1; #1;
    checks++; if ({ce_n, oe_n, we_n, be_n} !== 5'b11111) begin failures++; $display("FAIL abort_strobes got=%b exp=11111", {ce_n, oe_n, we_n, be_n}); end
    probe_en = 1; probe_val = 16'hEDCB; #1;
    checks++; if (sram_data !== 16'hEDCB) begin failures++; $display("FAIL abort_bus_released got=%h exp=edcb", sram_data); end
    probe_en = 0;
    seen = rsp_valid ? 1 : 0;
    @(posedge clk); #1;
    rst = 0; #1;
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL abort_ready got=%b exp=1", req_ready); end
    for (int c = 0; c < 8; c++) begin @(posedge clk); #1; if (rsp_valid) seen++; end
    checks++; if (seen != 0) begin failures++; $display("FAIL abort_no_rsp got=%0d exp=0", seen); end
  endtask

  task automatic test_sweep();
    logic [DW2-1:0] rd; int lat;
    do2(1, 10'h3FF, 32'hDEADBEEF, 4'hF, rd, lat); ref2[32'h3FF] = 32'hDEADBEEF;
    checks++; if (lat != WW2 + 2) begin failures++; $display("FAIL sweep_wr_latency got=%0d exp=%0d", lat, WW2 + 2); end
    checks++; if (last_len2 != WW2) begin failures++; $display("FAIL sweep_pulse_len got=%0d exp=%0d", last_len2, WW2); end
    do2(1, 10'h000, 32'h01234567, 4'hF, rd, lat); ref2[0] = 32'h01234567;
    do2(0, 10'h3FF, '0, 4'h0, rd, lat);
    checks++; if (lat != RW2) begin failures++; $display("FAIL sweep_rd_latency got=%0d exp=%0d", lat, RW2); end
    checks++; if (rd !== ref2[32'h3FF]) begin failures++; $display("FAIL sweep_top_data got=%h exp=%h", rd, ref2[32'h3FF]); end
    checks++; if (req_ready2 !== 1'b1) begin failures++; $display("FAIL sweep_ready_with_rsp got=%b exp=1", req_ready2); end
    do2(0, 10'h000, '0, 4'h0, rd, lat);
    checks++; if (rd !== ref2[0]) begin failures++; $display("FAIL sweep_low_data got=%h exp=%h", rd, ref2[0]); end
  endtask

  task automatic test_invariants();
    checks++; if (viol1 != 0) begin failures++; $display("FAIL bus_invariants got=%0d exp=0", viol1); end
    checks++; if (viol2 != 0) begin failures++; $display("FAIL sweep_bus_invariants got=%0d exp=0", viol2); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_lanes();
    test_turnaround();
    test_streaming();
    test_random();
    test_reset_mid_write();
    test_sweep();
    test_invariants();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
